// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory requester and the memory it drives,
// so both sides agree on depth, widths and state encoding.
package data_mem_pkg;

   localparam int unsigned DM_MEM_WORDS = 10;
   localparam int unsigned DM_DATA_W    = 32;
   localparam int unsigned DM_ADDR_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } dm_state_e;

endpackage

// File: rtl/data_mem_requester.sv
// Initiator side of the data-memory interface: one load/store per request
// handshake, one response per request, registered single-cycle memory strobes.
module data_mem_requester
   import data_mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = DM_MEM_WORDS,
   parameter int unsigned DATA_W    = DM_DATA_W,
   parameter int unsigned ADDR_W    = DM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] Mem_address,
   output logic              Mem_read,
   output logic              Mem_write,
   output logic [DATA_W-1:0] Write_data,
   input  logic [DATA_W-1:0] Read_Data
);

   dm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              out_of_range;

   assign out_of_range = (req_addr >= ADDR_W'(MEM_WORDS));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               rdata_d = '0;
               err_d   = out_of_range;
               // Address/data registers double as the memory-side outputs, so
               // they are only loaded when an access is actually issued.
               if (out_of_range) begin
                  state_d = ST_RESP;
               end else if (req_write) begin
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  wr_d    = 1'b1;
                  state_d = ST_WRITE;
               end else begin
                  addr_d  = req_addr;
                  rd_d    = 1'b1;
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            rdata_d = Read_Data;
            state_d = ST_RESP;
         end
         ST_WRITE: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign Mem_address = addr_q;
   assign Write_data  = wdata_q;
   assign Mem_read    = rd_q;
   assign Mem_write   = wr_q;
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Directed bench for data_mem_requester with a behavioural data memory that
// reads on Mem_read rising and writes at negedge clk.
module tb_data_mem_requester;

   localparam int unsigned MW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic [AW-1:0] Mem_address;
   logic          Mem_read;
   logic          Mem_write;
   logic [DW-1:0] Write_data;
   logic [DW-1:0] Read_Data;

   logic [DW-1:0] mem [MW];
   int            rd_rises;
   int            wr_rises;
   int            checks;
   int            errors;

   data_mem_requester #(
      .MEM_WORDS(MW),
      .DATA_W   (DW),
      .ADDR_W   (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .Mem_address(Mem_address),
      .Mem_read   (Mem_read),
      .Mem_write  (Mem_write),
      .Write_data (Write_data),
      .Read_Data  (Read_Data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      mem[0] = 32'd4; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd5; mem[4] = 32'd1;
      mem[5] = 32'd6; mem[6] = 32'd8; mem[7] = 32'd0; mem[8] = 32'd7; mem[9] = 32'd4;
      Read_Data = '0;
   end

   always @(posedge Mem_read) begin
      #1;
      if (Mem_address < AW'(MW)) Read_Data = mem[Mem_address];
   end

   always @(negedge clk) begin
      if (Mem_write === 1'b1 && Mem_address < AW'(MW)) mem[Mem_address] = Write_data;
   end

   always @(posedge Mem_read)  rd_rises++;
   always @(posedge Mem_write) wr_rises++;

   always @(posedge clk) begin
      if (Mem_read === 1'b1 && Mem_write === 1'b1) begin
         errors++;
         $display("FAIL strobe_excl: Mem_read=1 and Mem_write=1 together at %0t", $time);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; resp_ready = 1'b1;
      #2;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
      checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
      checks++; if (Mem_read !== 1'b0 || Mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobes: rd=%b wr=%b exp 0 0", Mem_read, Mem_write); end
      checks++; if (Mem_address !== '0 || Write_data !== '0) begin errors++; $display("FAIL rst_mem_bus: addr=%h wd=%h exp 0 0", Mem_address, Write_data); end
      #10;
      reset = 1'b1;
      step();
   endtask

   task automatic test_load();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd3;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b exp 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (Mem_read !== 1'b1 || Mem_address !== 32'd3) begin errors++; $display("FAIL load_strobe: rd=%b addr=%0d exp 1 3", Mem_read, Mem_address); end
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL load_busy: resp_valid=%b req_ready=%b exp 0 0", resp_valid, req_ready); end
      step();
      checks++; if (Mem_read !== 1'b0) begin errors++; $display("FAIL load_rd_drop: got %b exp 0", Mem_read); end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd5 || resp_err !== 1'b0) begin errors++; $display("FAIL load_resp: v=%b d=%h e=%b exp 1 5 0", resp_valid, resp_rdata, resp_err); end
      step();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL load_idle: v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
   endtask

   task automatic test_store_then_load();
      int rr;
      rr = rd_rises;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'hDEADBEEF;
      step();
      req_valid = 1'b0;
      checks++; if (Mem_write !== 1'b1 || Mem_read !== 1'b0) begin errors++; $display("FAIL store_strobe: wr=%b rd=%b exp 1 0", Mem_write, Mem_read); end
      checks++; if (Mem_address !== 32'd7 || Write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_bus: addr=%0d wd=%h exp 7 deadbeef", Mem_address, Write_data); end
      step();
      checks++; if (Mem_write !== 1'b0) begin errors++; $display("FAIL store_wr_drop: got %b exp 0", Mem_write); end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== '0 || resp_err !== 1'b0) begin errors++; $display("FAIL store_resp: v=%b d=%h e=%b exp 1 0 0", resp_valid, resp_rdata, resp_err); end
      checks++; if (mem[7] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_commit: mem[7]=%h exp deadbeef", mem[7]); end
      checks++; if (rd_rises !== rr) begin errors++; $display("FAIL store_no_read: read rises=%0d exp %0d", rd_rises, rr); end
      step();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd7;
      step();
      req_valid = 1'b0;
      checks++; if (Mem_read !== 1'b1 || Mem_address !== 32'd7) begin errors++; $display("FAIL reload_strobe: rd=%b addr=%0d exp 1 7", Mem_read, Mem_address); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_resp: v=%b d=%h exp 1 deadbeef", resp_valid, resp_rdata); end
      step();
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0;
      step();
      req_addr = 32'd9;
      checks++; if (Mem_read !== 1'b1 || Mem_address !== 32'd0) begin errors++; $display("FAIL b2b_first_strobe: rd=%b addr=%0d exp 1 0", Mem_read, Mem_address); end
      step();
      checks++; if (Mem_read !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap1: rd=%b rdy=%b exp 0 0", Mem_read, req_ready); end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd4) begin errors++; $display("FAIL b2b_resp1: v=%b d=%h exp 1 4", resp_valid, resp_rdata); end
      step();
      checks++; if (Mem_read !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap2: rd=%b rdy=%b v=%b exp 0 1 0", Mem_read, req_ready, resp_valid); end
      step();
      req_valid = 1'b0;
      checks++; if (Mem_read !== 1'b1 || Mem_address !== 32'd9) begin errors++; $display("FAIL b2b_second_strobe: rd=%b addr=%0d exp 1 9", Mem_read, Mem_address); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd4) begin errors++; $display("FAIL b2b_resp2: v=%b d=%h exp 1 4", resp_valid, resp_rdata); end
      step();
   endtask

   task automatic test_out_of_range();
      int rr, wr;
      rr = rd_rises; wr = wr_rises;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd10;
      step();
      req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== '0) begin errors++; $display("FAIL oor_resp: v=%b e=%b d=%h exp 1 1 0", resp_valid, resp_err, resp_rdata); end
      checks++; if (Mem_address !== 32'd9) begin errors++; $display("FAIL oor_addr_hold: got %0d exp 9", Mem_address); end
      step();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL oor_idle: v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
      checks++; if (rd_rises !== rr || wr_rises !== wr) begin errors++; $display("FAIL oor_no_strobe: rd=%0d wr=%0d exp %0d %0d", rd_rises, wr_rises, rr, wr); end
   endtask

   task automatic test_backpressure();
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1;
      step();
      req_valid = 1'b0;
      step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd2 || resp_err !== 1'b0) begin errors++; $display("FAIL bp_resp: v=%b d=%h e=%b exp 1 2 0", resp_valid, resp_rdata, resp_err); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'd2 || req_ready !== 1'b0 || Mem_read !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall%0d: v=%b d=%h rdy=%b rd=%b exp 1 2 0 0", i, resp_valid, resp_rdata, req_ready, Mem_read);
         end
      end
      resp_ready = 1'b1;
      step();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
   endtask

   task automatic test_reset_mid_read();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2;
      step();
      req_valid = 1'b0;
      checks++; if (Mem_read !== 1'b1) begin errors++; $display("FAIL rmr_in_read: rd=%b exp 1", Mem_read); end
      #1;
      reset = 1'b0;
      #1;
      checks++; if (Mem_read !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rmr_async: rd=%b v=%b exp 0 0", Mem_read, resp_valid); end
      checks++; if (Mem_address !== '0) begin errors++; $display("FAIL rmr_addr: got %h exp 0", Mem_address); end
      #10;
      reset = 1'b1;
      step();
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rmr_idle: rdy=%b v=%b exp 1 0", req_ready, resp_valid); end
      step();
      checks++; if (resp_valid !== 1'b0 || Mem_read !== 1'b0) begin errors++; $display("FAIL rmr_no_resp: v=%b rd=%b exp 0 0", resp_valid, Mem_read); end
   endtask

   initial begin
      checks = 0; errors = 0; rd_rises = 0; wr_rises = 0;
      test_reset();
      test_load();
      test_store_then_load();
      test_back_to_back();
      test_out_of_range();
      test_backpressure();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded 20000 time units");
      $fatal(1, "timeout");
   end

endmodule
